// File: rtl/bram_fetch.sv
// rtl/bram_fetch.sv - BRAM readout engine streaming N words through a credit-controlled FIFO
//
// Purpose: on start, reads word_count consecutive 32-bit words from a BRAM with
// fixed read latency and streams them out with a valid/ready handshake.
// Issue is throttled so that words in flight plus words already buffered can
// never exceed the output FIFO, so backpressure never loses data.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, word_count   begin a readout of word_count words (sampled in IDLE)
//   BRAM_read_address   byte address of the current read (4*k)
//   BRAM_en             read enable, one read issued per high cycle
//   BRAM_read_data      BRAM data, valid READ_LATENCY cycles after BRAM_en
//   data_out/data_valid/data_ready   output stream
//   busy                readout in progress
//   done                one-cycle completion pulse
module bram_fetch #(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] word_count,
    output logic [31:0] BRAM_read_address,
    output logic        BRAM_en,
    input  logic [31:0] BRAM_read_data,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        done
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [15:0]             r_n;
    logic [15:0]             r_issued;
    logic [15:0]             r_xfer;
    logic                    r_done;
    logic [READ_LATENCY-1:0] r_vpipe;
    logic [31:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_en;
    logic                    w_start_go;
    logic                    w_start_zero;
    logic                    w_last_issue;
    logic                    w_last_xfer;
    logic [CW-1:0]           w_inflight;
    logic [CW-1:0]           w_used;

    assign w_push       = r_vpipe[READ_LATENCY-1];
    assign w_pop        = (r_count != '0) && data_ready;
    assign w_start_go   = (r_state == S_IDLE) && start && (word_count != 16'd0);
    assign w_start_zero = (r_state == S_IDLE) && start && (word_count == 16'd0);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_vpipe[i]);
        end
    end

    // The word leaving the FIFO this cycle frees its slot before any new read
    // can land, so it is not counted; this keeps one word per cycle at
    // FIFO_DEPTH = READ_LATENCY + 1 while still guaranteeing no overflow.
    assign w_used = r_count - CW'(w_pop) + w_inflight;

    assign w_en         = (r_state == S_READ) && (r_issued < r_n) && (w_used < CW'(FIFO_DEPTH));
    assign w_last_issue = w_en && (r_issued == r_n - 16'd1);
    assign w_last_xfer  = (r_state == S_DRAIN) && w_pop && (r_xfer == r_n - 16'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_go)   w_next = S_READ;
            S_READ:  if (w_last_issue) w_next = S_DRAIN;
            S_DRAIN: if (w_last_xfer)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_n      <= '0;
            r_issued <= '0;
            r_xfer   <= '0;
            r_vpipe  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_start_zero || w_last_xfer;
            if (w_start_go) begin
                r_n      <= word_count;
                r_issued <= '0;
                r_xfer   <= '0;
            end else begin
                if (w_en)  r_issued <= r_issued + 16'd1;
                if (w_pop) r_xfer   <= r_xfer + 16'd1;
            end
            // Valid pipeline mirrors the BRAM latency; its last stage marks
            // the cycle in which BRAM_read_data belongs to an issued read.
            r_vpipe[0] <= w_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= BRAM_read_data;
    end

    assign BRAM_read_address = {14'd0, r_issued, 2'b00};
    assign BRAM_en           = w_en;
    assign data_valid        = (r_count != '0);
    // Masked when empty so stale storage never appears on data_out.
    assign data_out          = data_valid ? r_mem[r_rd_ptr] : 32'd0;
    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
endmodule

// File: tb/tb_bram_fetch.sv
// tb/tb_bram_fetch.sv - self-checking bench for bram_fetch at READ_LATENCY 1, 2 and 3
module tb_bram_fetch;
    logic        clk;
    logic        rst_n;
    logic [15:0] word_count;
    logic        data_ready;
    logic        start   [3];
    logic [31:0] addr    [3];
    logic        en      [3];
    logic [31:0] rdata   [3];
    logic [31:0] dout    [3];
    logic        dv      [3];
    logic        busy_o  [3];
    logic        done_o  [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    int issued   [3];
    int deliv    [3];
    int exp_n    [3];
    int first_en [3];
    int last_en  [3];
    int first_dv [3];
    int last_dv  [3];
    int done_cyc [3];
    bit exp_busy [3];
    bit exp_done [3];
    bit prev_valid [3];
    logic [31:0] prev_data [3];
    bit prev_ready;

    bram_fetch #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .word_count(word_count),
        .BRAM_read_address(addr[0]), .BRAM_en(en[0]), .BRAM_read_data(rdata[0]),
        .data_out(dout[0]), .data_valid(dv[0]), .data_ready(data_ready),
        .busy(busy_o[0]), .done(done_o[0]));

    bram_fetch #(.READ_LATENCY(2), .FIFO_DEPTH(4)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .word_count(word_count),
        .BRAM_read_address(addr[1]), .BRAM_en(en[1]), .BRAM_read_data(rdata[1]),
        .data_out(dout[1]), .data_valid(dv[1]), .data_ready(data_ready),
        .busy(busy_o[1]), .done(done_o[1]));

    bram_fetch #(.READ_LATENCY(3), .FIFO_DEPTH(4)) u_l3 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .word_count(word_count),
        .BRAM_read_address(addr[2]), .BRAM_en(en[2]), .BRAM_read_data(rdata[2]),
        .data_out(dout[2]), .data_valid(dv[2]), .data_ready(data_ready),
        .busy(busy_o[2]), .done(done_o[2]));

    // BRAM models: word k = 0xA000_0000 + k, returned exactly g+1 cycles after
    // the enable; outside that window the bus carries a poison value.
    for (genvar g = 0; g < 3; g++) begin : g_bram
        logic [31:0] a_pipe [3];
        logic        e_pipe [3];
        always @(posedge clk) begin
            a_pipe[0] <= addr[g];
            e_pipe[0] <= en[g];
            a_pipe[1] <= a_pipe[0];
            e_pipe[1] <= e_pipe[0];
            a_pipe[2] <= a_pipe[1];
            e_pipe[2] <= e_pipe[1];
        end
        assign rdata[g] = e_pipe[g] ? (32'hA000_0000 + (a_pipe[g] >> 2)) : 32'hDEAD_BEEF;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s L=%0d cycle=%0d observed=%h expected=%h", tag, idx + 1, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            issued[i] = 0; deliv[i] = 0; exp_n[i] = 0;
            exp_busy[i] = 0; exp_done[i] = 0; prev_valid[i] = 0;
            first_en[i] = -1; last_en[i] = -1; first_dv[i] = -1; last_dv[i] = -1; done_cyc[i] = -1;
        end
        prev_ready = 0;
    endtask

    // Compares this cycle's outputs with the stream-level model and then
    // advances the model by what the handshake and start do at the next edge.
    task automatic monitor();
        for (int i = 0; i < 3; i++) begin
            bit busy_nx;
            bit done_nx;
            bit allowed;
            busy_nx = exp_busy[i];
            done_nx = 1'b0;
            chk("busy", i, busy_o[i], exp_busy[i]);
            chk("done", i, done_o[i], exp_done[i]);
            allowed = exp_busy[i] && (issued[i] < exp_n[i]);
            chk("en_not_allowed", i, en[i] & ~allowed, 1'b0);
            chk("credit", i, (issued[i] - deliv[i]) <= 4, 1'b1);
            if (!exp_busy[i]) chk("idle_valid", i, dv[i], 1'b0);
            if (prev_valid[i] && !prev_ready) begin
                chk("stall_valid", i, dv[i], 1'b1);
                chk("stall_data", i, dout[i], prev_data[i]);
            end
            if (en[i]) begin
                chk("addr", i, addr[i], 32'(issued[i] * 4));
                if (first_en[i] < 0) first_en[i] = cyc;
                last_en[i] = cyc;
                issued[i]++;
            end
            if (dv[i] && data_ready) begin
                chk("extra_word", i, deliv[i] < exp_n[i], 1'b1);
                chk("data", i, dout[i], 32'hA000_0000 + 32'(deliv[i]));
                if (first_dv[i] < 0) first_dv[i] = cyc;
                last_dv[i] = cyc;
                deliv[i]++;
                if (deliv[i] == exp_n[i]) begin
                    busy_nx = 1'b0;
                    done_nx = 1'b1;
                end
            end
            if (done_o[i]) done_cyc[i] = cyc;
            if (start[i] && !exp_busy[i]) begin
                if (word_count != 16'd0) begin
                    busy_nx   = 1'b1;
                    exp_n[i]  = int'(word_count);
                    issued[i] = 0;
                    deliv[i]  = 0;
                end else begin
                    done_nx = 1'b1;
                end
            end
            prev_valid[i] = dv[i];
            prev_data[i]  = dout[i];
            exp_busy[i]   = busy_nx;
            exp_done[i]   = done_nx;
        end
        prev_ready = data_ready;
    endtask

    task automatic step(input logic rdy);
        tick();
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        data_ready = rdy;
        #1 monitor();
    endtask

    task automatic go(input logic [2:0] mask, input logic [15:0] wc);
        tick();
        for (int i = 0; i < 3; i++) begin
            start[i] = mask[i];
            if (mask[i]) begin
                first_en[i] = -1; last_en[i] = -1;
                first_dv[i] = -1; last_dv[i] = -1; done_cyc[i] = -1;
            end
        end
        word_count = wc;
        data_ready = 1'b1;
        t0 = cyc;
        #1 monitor();
    endtask

    task automatic pulse_start(input logic [15:0] wc);
        tick();
        for (int i = 0; i < 3; i++) start[i] = 1'b1;
        word_count = wc;
        data_ready = 1'b1;
        #1 monitor();
    endtask

    function automatic bit all_idle();
        bit r;
        r = 1'b1;
        for (int i = 0; i < 3; i++) if (exp_busy[i] || exp_done[i]) r = 1'b0;
        return r;
    endfunction

    task automatic run_until_idle(input int bound, input bit rnd);
        int  k;
        int  run;
        logic r;
        k = 0; run = 0; r = 1'b1;
        while (k < bound && !all_idle()) begin
            if (rnd) begin
                if (run == 0) begin
                    r   = ~r;
                    run = r ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 12));
                end
                run--;
            end
            step(r);
            k++;
        end
        chk("timeout_idle", 0, all_idle(), 1'b1);
    endtask

    task automatic chk_zero(input int i);
        chk("rst_addr", i, addr[i], 32'd0);
        chk("rst_en", i, en[i], 1'b0);
        chk("rst_dout", i, dout[i], 32'd0);
        chk("rst_valid", i, dv[i], 1'b0);
        chk("rst_busy", i, busy_o[i], 1'b0);
        chk("rst_done", i, done_o[i], 1'b0);
    endtask

    task automatic timing_chk(input int n);
        for (int i = 0; i < 3; i++) begin
            chk("first_en", i, 32'(first_en[i]), 32'(t0 + 1));
            chk("last_en", i, 32'(last_en[i]), 32'(t0 + n));
            chk("first_valid", i, 32'(first_dv[i]), 32'(t0 + 2 + i + 1));
            chk("last_valid", i, 32'(last_dv[i]), 32'(t0 + 1 + i + 1 + n));
            chk("done_cycle", i, 32'(done_cyc[i]), 32'(t0 + 2 + i + 1 + n));
            chk("word_total", i, 32'(deliv[i]), 32'(n));
        end
    endtask

    initial begin
        int k;
        int n;
        rst_n      = 1'b0;
        word_count = 16'd0;
        data_ready = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        model_clear();

        tick();
        #1 for (int i = 0; i < 3; i++) chk_zero(i);
        tick();
        rst_n = 1'b1;
        #1 monitor();

        // Basic 8-word readout on all three latencies.
        go(3'b111, 16'd8);
        run_until_idle(200, 1'b0);
        timing_chk(8);

        // Zero length: done in cycle 1 only, no reads.
        go(3'b111, 16'd0);
        run_until_idle(20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("zero_done_cycle", i, 32'(done_cyc[i]), 32'(t0 + 1));
            chk("zero_no_en", i, 32'(first_en[i]), 32'hFFFF_FFFF);
        end

        // Random backpressure with long low stretches.
        go(3'b111, 16'd16);
        run_until_idle(3000, 1'b1);
        for (int i = 0; i < 3; i++) chk("bp_total", i, 32'(deliv[i]), 32'd16);

        // Start while busy is ignored.
        go(3'b111, 16'd8);
        step(1'b1);
        step(1'b1);
        pulse_start(16'd3);
        run_until_idle(200, 1'b0);
        for (int i = 0; i < 3; i++) chk("busy_start_total", i, 32'(deliv[i]), 32'd8);

        // Reset after three transfers of an 8-word read.
        go(3'b010, 16'd8);
        k = 0;
        while (k < 100 && deliv[1] < 3) begin
            step(1'b1);
            k++;
        end
        chk("timeout_three", 1, 32'(deliv[1]), 32'd3);
        tick();
        data_ready = 1'b1;
        rst_n = 1'b0;
        #1 for (int i = 0; i < 3; i++) chk_zero(i);
        model_clear();
        step(1'b1);
        step(1'b1);
        tick();
        rst_n = 1'b1;
        #1 monitor();
        go(3'b111, 16'd2);
        run_until_idle(100, 1'b0);
        for (int i = 0; i < 3; i++) chk("post_reset_total", i, 32'(deliv[i]), 32'd2);

        // Random-length sweep at full throughput.
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 24));
            go(3'b111, 16'(n));
            run_until_idle(300, 1'b0);
            timing_chk(n);
        end

        step(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
